datapath_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle 8-bit datapath. It provides a register file of `NREG` words of `WIDTH` bits, an operand-B source mux (register or `constante`), and an 8-operation ULA with a registered result and flags. The result is written back into the register file automatically, and results are forwarded to back-to-back dependent operations. The block sits between the control unit, which issues one operation per cycle, and any consumer of `ULAResult` and the flags; an external write port loads initial register contents.

---
 rtl/datapath_pipe.sv | 190 +++++++++++++++++++
 tb/tb_datapath_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// datapath_pipe: register file, operand-B mux and 8-op ULA in two stages,
// with automatic write-back and forwarding of the in-flight S1 result.
module datapath_pipe #(
   parameter int WIDTH = 8,
   parameter int NREG  = 8,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   input  logic [WIDTH-1:0] constante,
   input  logic             select_src,
   input  logic [2:0]       ULAControl,
   input  logic             wb_en,
   input  logic [AW-1:0]    wa,
   input  logic             ext_we,
   input  logic [AW-1:0]    ext_wa,
   input  logic [WIDTH-1:0] ext_wd,
   output logic             out_valid,
   output logic [WIDTH-1:0] ULAResult,
   output logic             CarryOut,
   output logic             Flag_z,
   output logic             Flag_n,
   output logic             Flag_v
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_ADDC = 3'b110;
   localparam logic [2:0] OP_SLTS = 3'b111;

   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] rf_d [NREG];

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             s1_wb_q, s1_wb_d;
   logic [AW-1:0]    s1_wa_q, s1_wa_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             c_q, c_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             v_q, v_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] add_b;
   logic             add_ci;
   logic             ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   logic             fwd1, fwd2;
   logic [WIDTH-1:0] op_a, rd_b, op_b;

   // Subtraction reuses the adder as A + ~B + 1; borrow is the inverted carry.
   always_comb begin
      add_b  = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;
      add_ci = 1'b0;
      if (s1_op_q == OP_SUB)
         add_ci = 1'b1;
      else if (s1_op_q == OP_ADDC)
         add_ci = c_q;
      sum = {1'b0, s1_a_q} + {1'b0, add_b}
          + {{WIDTH{1'b0}}, add_ci};
      ovf = (s1_a_q[WIDTH-1] == add_b[WIDTH-1])
         && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (s1_op_q)
         OP_ADD, OP_ADDC: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = ovf;
         end
         OP_SUB: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = ~sum[WIDTH];
            alu_v   = ovf;
         end
         OP_AND:  alu_res = s1_a_q & s1_b_q;
         OP_OR:   alu_res = s1_a_q | s1_b_q;
         OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, s1_a_q < s1_b_q};
         OP_SLTS: alu_res = {{(WIDTH-1){1'b0}},
                             $signed(s1_a_q) < $signed(s1_b_q)};
      endcase
   end

   always_comb begin
      fwd1 = s1_valid_q && s1_wb_q && (s1_wa_q == ra1);
      fwd2 = s1_valid_q && s1_wb_q && (s1_wa_q == ra2);
      op_a = fwd1 ? alu_res : rf_q[ra1];
      rd_b = fwd2 ? alu_res : rf_q[ra2];
      op_b = select_src ? constante : rd_b;
   end

   // Write-back is applied last so it wins over a same-address external write.
   always_comb begin
      rf_d = rf_q;
      if (ext_we)
         rf_d[ext_wa] = ext_wd;
      if (s1_valid_q && s1_wb_q)
         rf_d[s1_wa_q] = alu_res;
   end

   always_comb begin
      s1_valid_d = in_valid;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_wb_d    = s1_wb_q;
      s1_wa_d    = s1_wa_q;
      if (in_valid) begin
         s1_a_d  = op_a;
         s1_b_d  = op_b;
         s1_op_d = ULAControl;
         s1_wb_d = wb_en;
         s1_wa_d = wa;
      end
   end

   always_comb begin
      out_valid_d = s1_valid_q;
      res_d       = res_q;
      c_d         = c_q;
      z_d         = z_q;
      n_d         = n_q;
      v_d         = v_q;
      if (s1_valid_q) begin
         res_d = alu_res;
         c_d   = alu_c;
         z_d   = (alu_res == '0);
         n_d   = alu_res[WIDTH-1];
         v_d   = alu_v;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         s1_wb_q     <= 1'b0;
         s1_wa_q     <= '0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
      end else begin
         rf_q        <= rf_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         s1_wb_q     <= s1_wb_d;
         s1_wa_q     <= s1_wa_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         c_q         <= c_d;
         z_q         <= z_d;
         n_q         <= n_d;
         v_q         <= v_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ULAResult = res_q;
   assign CarryOut  = c_q;
   assign Flag_z    = z_q;
   assign Flag_n    = n_q;
   assign Flag_v    = v_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: architectural model in program order plus
// directed cases with literal results and a long random run.
module tb_datapath_pipe;

   localparam logic [2:0] ADD  = 3'd0;
   localparam logic [2:0] SUB  = 3'd1;
   localparam logic [2:0] SLT  = 3'd5;
   localparam logic [2:0] ADDC = 3'd6;
   localparam logic [2:0] SLTS = 3'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] ra1 = '0, ra2 = '0, wa = '0, ext_wa = '0;
   logic [7:0] constante = '0, ext_wd = '0;
   logic       select_src = 1'b0, wb_en = 1'b0, ext_we = 1'b0;
   logic [2:0] ULAControl = '0;
   logic       out_valid, CarryOut, Flag_z, Flag_n, Flag_v;
   logic [7:0] ULAResult;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 0;

   datapath_pipe #(.WIDTH(8), .NREG(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .ra1(ra1), .ra2(ra2), .constante(constante),
      .select_src(select_src), .ULAControl(ULAControl),
      .wb_en(wb_en), .wa(wa), .ext_we(ext_we),
      .ext_wa(ext_wa), .ext_wd(ext_wd),
      .out_valid(out_valid), .ULAResult(ULAResult),
      .CarryOut(CarryOut), .Flag_z(Flag_z),
      .Flag_n(Flag_n), .Flag_v(Flag_v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void ref_alu(input logic [7:0] a, b,
                                   input logic [2:0] op, input logic ci,
                                   output logic [7:0] r,
                                   output logic c, output logic v);
      int ua, ub, sa, sb, t, s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      t = 0;
      s = 0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0: begin
            t = ua + ub; s = sa + sb;
            c = t > 255; v = (s > 127) || (s < -128);
         end
         3'd1: begin
            t = ua - ub; s = sa - sb;
            c = ua < ub; v = (s > 127) || (s < -128);
         end
         3'd2: t = ua & ub;
         3'd3: t = ua | ub;
         3'd4: t = ua ^ ub;
         3'd5: t = (ua < ub) ? 1 : 0;
         3'd6: begin
            t = ua + ub + int'(ci); s = sa + sb + int'(ci);
            c = t > 255; v = (s > 127) || (s < -128);
         end
         default: t = (sa < sb) ? 1 : 0;
      endcase
      r = t[7:0];
   endfunction

   // Model: each op sees every earlier op's result immediately.
   logic [7:0] m_rf [8];
   logic       m_c, m_prev_wb, p_valid, p_c, p_v;
   logic [2:0] m_prev_wa;
   logic [7:0] p_res;
   logic       e_valid, e_c, e_z, e_n, e_v;
   logic [7:0] e_res;

   always @(posedge clk) begin : model
      logic [7:0] a, b, r;
      logic c, v;
      if (reset) begin
         for (int i = 0; i < 8; i++) m_rf[i] = '0;
         m_c = 0; m_prev_wb = 0; m_prev_wa = '0;
         p_valid = 0; p_res = '0; p_c = 0; p_v = 0;
         e_valid = 0; e_res = '0;
         e_c = 0; e_z = 0; e_n = 0; e_v = 0;
      end else begin
         e_valid = p_valid;
         if (p_valid) begin
            e_res = p_res; e_c = p_c; e_v = p_v;
            e_z = (p_res == 8'd0); e_n = p_res[7];
         end
         a = m_rf[ra1];
         b = select_src ? constante : m_rf[ra2];
         if (ext_we && !(m_prev_wb && m_prev_wa == ext_wa))
            m_rf[ext_wa] = ext_wd;
         p_valid = in_valid;
         if (in_valid) begin
            ref_alu(a, b, ULAControl, m_c, r, c, v);
            m_c = c; p_res = r; p_c = c; p_v = v;
            if (wb_en) m_rf[wa] = r;
         end
         m_prev_wb = in_valid && wb_en;
         m_prev_wa = wa;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out_valid", out_valid, e_valid);
         chk("ULAResult", ULAResult, e_res);
         chk("CarryOut", CarryOut, e_c);
         chk("Flag_z", Flag_z, e_z);
         chk("Flag_n", Flag_n, e_n);
         chk("Flag_v", Flag_v, e_v);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      ext_we = 0;
      reset = 0;
   endtask

   task automatic op(input logic [2:0] code, input logic [2:0] a1, a2,
                     input logic sel, input logic [7:0] k,
                     input logic wb, input logic [2:0] w);
      in_valid = 1; ULAControl = code; ra1 = a1; ra2 = a2;
      select_src = sel; constante = k; wb_en = wb; wa = w;
   endtask

   task automatic ext(input logic [2:0] a, input logic [7:0] d);
      ext_we = 1; ext_wa = a; ext_wd = d;
   endtask

   // Flags argument is {C, Z, N, V}.
   task automatic lit(input string nm, input logic vld,
                      input logic [7:0] r, input logic [3:0] f);
      chk({nm, ".valid"}, out_valid, vld);
      chk({nm, ".res"}, ULAResult, r);
      chk({nm, ".cznv"}, {CarryOut, Flag_z, Flag_n, Flag_v}, f);
      chk({nm, ".model"}, e_res, r);
   endtask

   initial begin
      reset = 1;
      tick();
      cmp_en = 1;
      lit("reset", 0, 8'h00, 4'b0000);

      ext(1, 8'd5); tick();
      ext(2, 8'd3); tick();
      op(ADD, 1, 2, 0, 0, 1, 3); tick();
      op(ADD, 3, 0, 0, 0, 0, 0); tick();
      lit("add", 1, 8'd8, 4'b0000);
      tick();
      lit("add_r3", 1, 8'd8, 4'b0000);

      op(ADD, 1, 2, 0, 0, 1, 4); tick();
      op(SUB, 4, 1, 0, 0, 0, 0); tick();
      lit("fwd_src", 1, 8'd8, 4'b0000);
      tick();
      lit("fwd_sub", 1, 8'd3, 4'b0000);
      op(ADD, 4, 0, 0, 0, 0, 0); tick(); tick();
      lit("r4", 1, 8'd8, 4'b0000);

      ext(5, 8'hFF); tick();
      ext(6, 8'h01); tick();
      op(ADD, 5, 6, 0, 0, 0, 0); tick();
      op(ADDC, 1, 0, 1, 8'h00, 0, 0); tick();
      lit("carry_add", 1, 8'h00, 4'b1100);
      tick();
      lit("addc", 1, 8'd6, 4'b0000);

      op(SUB, 2, 1, 0, 0, 0, 0); tick(); tick();
      lit("sub_borrow", 1, 8'hFE, 4'b1010);
      ext(7, 8'h80); tick();
      op(SLTS, 7, 0, 1, 8'h01, 0, 0); tick();
      op(SLT, 7, 0, 1, 8'h01, 0, 0); tick();
      lit("slts", 1, 8'd1, 4'b0000);
      tick();
      lit("slt_u", 1, 8'd0, 4'b0100);
      op(SLT, 2, 1, 0, 0, 0, 0); tick(); tick();
      lit("slt", 1, 8'd1, 4'b0000);
      ext(6, 8'h7F); tick();
      op(ADD, 6, 0, 1, 8'h01, 0, 0); tick(); tick();
      lit("ovf", 1, 8'h80, 4'b0011);

      op(ADD, 1, 2, 0, 0, 1, 3); tick();
      ext(3, 8'hAA); tick();
      op(ADD, 3, 0, 0, 0, 0, 0); tick(); tick();
      lit("wb_wins", 1, 8'd8, 4'b0000);

      op(ADD, 1, 2, 0, 0, 1, 7); tick();
      reset = 1; tick();
      lit("rst_mid", 0, 8'h00, 4'b0000);
      op(ADD, 7, 0, 0, 0, 0, 0); tick(); tick();
      lit("r7", 1, 8'h00, 4'b0100);

      for (int i = 0; i < 10000; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         ULAControl = 3'($urandom_range(0, 7));
         ra1        = 3'($urandom_range(0, 7));
         ra2        = 3'($urandom_range(0, 7));
         select_src = 1'($urandom_range(0, 1));
         constante  = 8'($urandom_range(0, 255));
         wb_en      = 1'($urandom_range(0, 1));
         wa         = 3'($urandom_range(0, 7));
         ext_we     = ($urandom_range(0, 2) == 0);
         ext_wa     = 3'($urandom_range(0, 7));
         ext_wd     = 8'($urandom_range(0, 255));
         reset      = ($urandom_range(0, 199) == 0);
         tick();
      end
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
